// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, control FSM states and
// the iterative engine mode.
package alu_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_MUL = 4'd7,
    OP_DIV = 4'd8,
    OP_MOD = 4'd9
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

  // DIV and MOD share the restoring divider and the divide-by-zero shortcut.
  function automatic logic is_divide(input op_t o);
    return (o == OP_DIV) || (o == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative multiply / divide engine. One product or quotient bit per
// cycle; `last` pulses for one cycle once all N steps are complete.
// MUL:  {hi, lo} = a * b.
// DIV:  lo = a / b (quotient), hi = a % b (remainder); b must be non-zero.
module alu_iter
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  mode_t        mode,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         last
);

  localparam int CW = $clog2(N);

  logic [N-1:0]  hi_q, hi_d;
  logic [N-1:0]  lo_q, lo_d;
  logic [N-1:0]  b_q, b_d;
  mode_t         mode_q, mode_d;
  logic          run_q, run_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N:0]    mul_sum;
  logic [N:0]    div_shift;
  logic [N:0]    div_diff;

  // Step logic: shift-add for MUL, restoring subtract for DIV.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + ({(N+1){lo_q[0]}} & {1'b0, b_q});
    div_shift = {hi_q, lo_q[N-1]};
    div_diff  = div_shift - {1'b0, b_q};

    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    mode_d = mode_q;
    run_d  = run_q;
    cnt_d  = cnt_q;
    last_d = 1'b0;

    if (load) begin
      hi_d   = '0;
      lo_d   = a;
      b_d    = b;
      mode_d = mode;
      run_d  = 1'b1;
      cnt_d  = CW'(N - 1);
    end else if (run_q) begin
      if (mode_q == MODE_MUL) begin
        // Multiplier is consumed from lo's LSB while the product enters at the top.
        hi_d = mul_sum[N:1];
        lo_d = {mul_sum[0], lo_q[N-1:1]};
      end else if (!div_diff[N]) begin
        // Partial remainder >= divisor: keep the difference, quotient bit 1.
        hi_d = div_diff[N-1:0];
        lo_d = {lo_q[N-2:0], 1'b1};
      end else begin
        // Restore: keep the shifted remainder, quotient bit 0.
        hi_d = div_shift[N-1:0];
        lo_d = {lo_q[N-2:0], 1'b0};
      end

      if (cnt_q == '0) begin
        run_d  = 1'b0;
        last_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      mode_q <= MODE_MUL;
      run_q  <= 1'b0;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      run_q  <= run_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign last = last_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: start/done handshake, one-cycle single ops, N-cycle
// MUL/DIV/MOD through alu_iter, and fully registered result and flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic [N-1:0] result_hi,
  output logic         busy,
  output logic         done,
  output logic         flag_neg,
  output logic         flag_zero,
  output logic         flag_carry,
  output logic         flag_over,
  output logic         flag_dz
);

  localparam int SW = $clog2(N);

  state_t       state_q, state_d;
  op_t          op_q;
  logic [N-1:0] a_q, b_q;
  logic         pend_q;

  op_t          op_in;
  logic         accept;
  logic         iter_in;

  logic [N-1:0] eng_hi, eng_lo;
  logic         eng_last;

  // Single-cycle datapath
  logic [SW-1:0] sh;
  logic [N:0]    sum, diff, shl;
  logic [N:0]    shr;
  logic [N-1:0]  s_res;
  logic          s_n, s_c, s_v, s_dz;

  // Iterative completion datapath
  logic [N-1:0]  f_res, f_hi;
  logic          f_c;

  logic [N-1:0]  result_q, result_d;
  logic [N-1:0]  result_hi_q, result_hi_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          neg_q, neg_d;
  logic          zero_q, zero_d;
  logic          carry_q, carry_d;
  logic          over_q, over_d;
  logic          dz_q, dz_d;

  assign op_in   = op_t'(op);
  assign accept  = start && (state_q == IDLE);
  // Divide by zero is resolved in one cycle instead of entering the divider.
  assign iter_in = (op_in == OP_MUL) || (is_divide(op_in) && (b != '0));

  alu_iter #(.N(N)) u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (accept && iter_in),
    .mode (is_divide(op_in) ? MODE_DIV : MODE_MUL),
    .a    (a),
    .b    (b),
    .hi   (eng_hi),
    .lo   (eng_lo),
    .last (eng_last)
  );

  // Next-state logic: RUN lasts until the engine reports its last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && iter_in) state_d = RUN;
      RUN:     if (eng_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand capture at accept; pend_q marks a single-cycle op due next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      pend_q <= 1'b0;
    end else begin
      pend_q <= accept && !iter_in;
      if (accept) begin
        op_q <= op_in;
        a_q  <= a;
        b_q  <= b;
      end
    end
  end

  // Single-cycle ops from the captured operands (DIV/MOD only reach here with b=0).
  always_comb begin
    sh    = b_q[SW-1:0];
    sum   = {1'b0, a_q} + {1'b0, b_q};
    diff  = {1'b0, a_q} - {1'b0, b_q};
    shl   = {1'b0, a_q} << sh;  // bit N holds the last bit shifted out
    shr   = {a_q, 1'b0} >> sh;  // bit 0 holds the last bit shifted out
    s_res = '0;
    s_n   = 1'b0;
    s_c   = 1'b0;
    s_v   = 1'b0;
    s_dz  = 1'b0;
    case (op_q)
      OP_ADD: begin
        s_res = sum[N-1:0];
        s_n   = sum[N-1];
        s_c   = sum[N];
        s_v   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
      end
      OP_SUB: begin
        s_res = diff[N-1:0];
        s_n   = diff[N-1];
        s_c   = diff[N];
        s_v   = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
      end
      OP_AND: s_res = a_q & b_q;
      OP_OR:  s_res = a_q | b_q;
      OP_XOR: s_res = a_q ^ b_q;
      OP_SHL: begin
        s_res = shl[N-1:0];
        s_c   = shl[N];
      end
      OP_SHR: begin
        s_res = shr[N:1];
        s_c   = shr[0];
      end
      OP_DIV: begin
        s_res = '1;
        s_dz  = 1'b1;
      end
      OP_MOD: begin
        s_res = a_q;
        s_dz  = 1'b1;
      end
      default: s_res = '0;
    endcase
  end

  // Map engine outputs to the result ports for the op that finished.
  always_comb begin
    f_res = (op_q == OP_MOD) ? eng_hi : eng_lo;
    f_hi  = (op_q == OP_MUL) ? eng_hi : '0;
    f_c   = (op_q == OP_MUL) && (eng_hi != '0);
  end

  // Output next-state: results and flags only move on the edge raising done.
  always_comb begin
    result_d    = result_q;
    result_hi_d = result_hi_q;
    neg_d       = neg_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    over_d      = over_q;
    dz_d        = dz_q;
    done_d      = 1'b0;
    busy_d      = (state_q == RUN) && !eng_last;

    if (pend_q) begin
      result_d    = s_res;
      result_hi_d = '0;
      neg_d       = s_n;
      zero_d      = (s_res == '0);
      carry_d     = s_c;
      over_d      = s_v;
      dz_d        = s_dz;
      done_d      = 1'b1;
    end else if ((state_q == RUN) && eng_last) begin
      result_d    = f_res;
      result_hi_d = f_hi;
      neg_d       = 1'b0;
      zero_d      = ({f_hi, f_res} == '0);
      carry_d     = f_c;
      over_d      = 1'b0;
      dz_d        = 1'b0;
      done_d      = 1'b1;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      result_hi_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      neg_q       <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      over_q      <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      neg_q       <= neg_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      over_q      <= over_d;
      dz_q        <= dz_d;
    end
  end

  assign result     = result_q;
  assign result_hi  = result_hi_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign flag_neg   = neg_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;
  assign flag_over  = over_q;
  assign flag_dz    = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (N=8 main instance, N=4 regression instance).
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // N=8 instance
  logic       start;
  logic [3:0] op;
  logic [7:0] a, b, result, result_hi;
  logic       busy, done, fn, fz, fc, fv, fdz;

  alu_seq #(.N(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .result_hi(result_hi), .busy(busy), .done(done),
    .flag_neg(fn), .flag_zero(fz), .flag_carry(fc), .flag_over(fv), .flag_dz(fdz)
  );

  // N=4 instance
  logic       start4;
  logic [3:0] op4;
  logic [3:0] a4, b4, result4, result_hi4;
  logic       busy4, done4, fn4, fz4, fc4, fv4, fdz4;

  alu_seq #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .a(a4), .b(b4),
    .result(result4), .result_hi(result_hi4), .busy(busy4), .done(done4),
    .flag_neg(fn4), .flag_zero(fz4), .flag_carry(fc4), .flag_over(fv4), .flag_dz(fdz4)
  );

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] hi;
    logic [4:0] flg;  // {neg, zero, carry, over, dz}
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference for N=8 built from integer arithmetic.
  function automatic exp_t model8(input int o, input int x, input int y);
    exp_t e;
    int r, r2, sx, sy, s, sh;
    logic n, c, v, dz;
    logic [7:0] res, hi;
    res = 8'd0; hi = 8'd0; n = 1'b0; c = 1'b0; v = 1'b0; dz = 1'b0;
    sx = (x > 127) ? x - 256 : x;
    sy = (y > 127) ? y - 256 : y;
    case (o)
      0: begin r = x + y; res = r[7:0]; c = (r > 255); s = sx + sy; v = (s > 127) || (s < -128); n = res[7]; end
      1: begin r = x - y; res = r[7:0]; c = (x < y);   s = sx - sy; v = (s > 127) || (s < -128); n = res[7]; end
      2: begin r = x & y; res = r[7:0]; end
      3: begin r = x | y; res = r[7:0]; end
      4: begin r = x ^ y; res = r[7:0]; end
      5: begin sh = y % 8; r = x << sh; res = r[7:0]; c = (sh != 0) ? r[8] : 1'b0; end
      6: begin
        sh = y % 8; r = x >> sh; res = r[7:0];
        r2 = (sh != 0) ? (x >> (sh - 1)) : 0; c = r2[0];
      end
      7: begin r = x * y; res = r[7:0]; hi = r[15:8]; c = (hi != 8'd0); end
      8: begin if (y == 0) begin res = 8'hFF; dz = 1'b1; end else begin r = x / y; res = r[7:0]; end end
      9: begin if (y == 0) begin r = x; dz = 1'b1; end else r = x % y; res = r[7:0]; end
      default: res = 8'd0;
    endcase
    e.res = res;
    e.hi  = hi;
    e.flg = {n, (res == 8'd0) && (hi == 8'd0), c, v, dz};
    return e;
  endfunction

  // Scoreboard monitor: pop and compare on every done pulse.
  exp_t  mon_e;
  string mon_t;
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", {31'd0, done}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        mon_t = tag_q.pop_front();
        check_val({mon_t, ".res"}, {24'd0, result}, {24'd0, mon_e.res});
        check_val({mon_t, ".hi"}, {24'd0, result_hi}, {24'd0, mon_e.hi});
        check_val({mon_t, ".flags"}, {27'd0, fn, fz, fc, fv, fdz}, {27'd0, mon_e.flg});
        $display("txn %s res=%02h hi=%02h flags(nzcvd)=%b", mon_t, result, result_hi, {fn, fz, fc, fv, fdz});
      end
    end
  end

  // Issue one op on the N=8 instance, wait for done, check latency and busy length.
  task automatic run_op(input string tag, input int o, input int x, input int y, input bit poke);
    int lat, bcnt, exp_lat;
    bit got;
    exp_lat = ((o == 7) || (((o == 8) || (o == 9)) && (y != 0))) ? 9 : 1;
    @(negedge clk);
    start = 1'b1; op = o[3:0]; a = x[7:0]; b = y[7:0];
    sb_q.push_back(model8(o, x, y));
    tag_q.push_back(tag);
    @(posedge clk); #1;
    start = 1'b0;
    op = 4'($urandom_range(0, 15)); a = 8'($urandom); b = 8'($urandom);
    lat = 0; bcnt = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); lat++; #1;
      if (busy) bcnt++;
      if (done) got = 1'b1;
      if (poke && lat == 3) begin start = 1'b1; op = 4'd0; end
      if (poke && lat == 4) start = 1'b0;
    end
    check_val({tag, ".lat"}, lat, exp_lat);
    check_val({tag, ".busy"}, bcnt, exp_lat - 1);
  endtask

  // Issue one op on the N=4 instance with spec-given expectations.
  task automatic run4(input string tag, input logic [3:0] o, input logic [3:0] x, input logic [3:0] y,
                      input logic [7:0] exp_full, input logic [4:0] exp_flg, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    start4 = 1'b1; op4 = o; a4 = x; b4 = y;
    @(posedge clk); #1;
    start4 = 1'b0;
    lat = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); lat++; #1;
      if (done4) got = 1'b1;
    end
    check_val({tag, ".lat"}, lat, exp_lat);
    check_val({tag, ".res"}, {24'd0, result_hi4, result4}, {24'd0, exp_full});
    check_val({tag, ".flags"}, {27'd0, fn4, fz4, fc4, fv4, fdz4}, {27'd0, exp_flg});
    $display("txn %s res=%h hi=%h flags(nzcvd)=%b", tag, result4, result_hi4, {fn4, fz4, fc4, fv4, fdz4});
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, second, o, x, y;
    bit saw;
    start = 1'b0; op = 4'd0; a = 8'd0; b = 8'd0;
    start4 = 1'b0; op4 = 4'd0; a4 = 4'd0; b4 = 4'd0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst.data", {16'd0, result_hi, result}, 32'd0);
    check_val("rst.ctl", {25'd0, busy, done, fn, fz, fc, fv, fdz}, 32'd0);
    check_val("rst.data4", {24'd0, result_hi4, result4}, 32'd0);
    @(negedge clk) rst = 1'b0;

    run_op("ADD200+100", 0, 200, 100, 1'b0);
    check_val("ADD.plan", {23'd0, result, fc, fv, fz}, {23'd0, 8'd44, 3'b100});
    run_op("SUB5-7", 1, 5, 7, 1'b0);
    check_val("SUB.plan", {22'd0, result, fn, fc}, {22'd0, 8'd254, 2'b11});
    run_op("MUL255x255", 7, 255, 255, 1'b1);
    check_val("MUL.plan", {15'd0, result_hi, result, fc}, {15'd0, 16'hFE01, 1'b1});
    run_op("DIV200/7", 8, 200, 7, 1'b0);
    check_val("DIV.plan", {24'd0, result}, 32'd28);
    run_op("MOD200/7", 9, 200, 7, 1'b0);
    check_val("MOD.plan", {24'd0, result}, 32'd4);
    run_op("DIV9/0", 8, 9, 0, 1'b0);
    check_val("DIVZ.plan", {23'd0, result, fdz}, {23'd0, 8'd255, 1'b1});
    run_op("MOD9/0", 9, 9, 0, 1'b0);
    run_op("SHL81by1", 5, 8'h81, 1, 1'b0);
    check_val("SHL.plan", {23'd0, result, fc}, {23'd0, 8'h02, 1'b1});
    run_op("SHR81by0", 6, 8'h81, 0, 1'b0);
    check_val("SHR0.plan", {23'd0, result, fc}, {23'd0, 8'h81, 1'b0});
    run_op("SHR81by9", 6, 8'h81, 9, 1'b0);
    check_val("SHR9.plan", {24'd0, result}, 32'h40);
    run_op("AND", 2, 8'hCC, 8'hAA, 1'b0);
    run_op("OR", 3, 8'h0C, 8'hA0, 1'b0);
    run_op("ADD127+1", 0, 127, 1, 1'b0);
    run_op("MUL0x77", 7, 0, 77, 1'b0);
    run_op("SUB128-1", 1, 128, 1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check_val("hold", {23'd0, result, done}, {23'd0, 8'd127, 1'b0});

    for (int i = 0; i < 12; i++) begin
      o = $urandom_range(0, 15);
      x = $urandom_range(0, 255);
      y = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 255);
      run_op($sformatf("RND%0d_op%0d", i, o), o, x, y, 1'b0);
    end

    // start held for two single-cycle ops on consecutive edges
    @(negedge clk);
    start = 1'b1; op = 4'd0; a = 8'd10; b = 8'd20;
    sb_q.push_back(model8(0, 10, 20)); tag_q.push_back("B2B_ADD");
    @(posedge clk); #1;
    op = 4'd4; a = 8'hF0; b = 8'h3C;
    sb_q.push_back(model8(4, 8'hF0, 8'h3C)); tag_q.push_back("B2B_XOR");
    @(posedge clk); #1;
    start = 1'b0;
    check_val("b2b.done0", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check_val("b2b.done1", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    check_val("b2b.idle", {31'd0, done}, 32'd0);

    // start held with an iterative op: second accept on the edge after done
    @(negedge clk);
    start = 1'b1; op = 4'd7; a = 8'd3; b = 8'd5;
    sb_q.push_back(model8(7, 3, 5)); tag_q.push_back("HOLD_MUL0");
    sb_q.push_back(model8(7, 3, 5)); tag_q.push_back("HOLD_MUL1");
    @(posedge clk);
    n = 0; first = -1; second = -1;
    while (second < 0 && n < 60) begin
      @(posedge clk); n++; #1;
      if (done) begin
        if (first < 0) first = n;
        else second = n;
      end
      if (first >= 0 && n == first + 1) start = 1'b0;
    end
    start = 1'b0;
    check_val("hold.first_done", first, 9);
    check_val("hold.second_done", second, 19);

    // reset in the middle of a MUL
    @(negedge clk);
    start = 1'b1; op = 4'd7; a = 8'd200; b = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rstmid.busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check_val("rstmid.data", {16'd0, result_hi, result}, 32'd0);
    check_val("rstmid.ctl", {25'd0, busy, done, fn, fz, fc, fv, fdz}, 32'd0);
    @(negedge clk) rst = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) saw = 1'b1;
    end
    check_val("rstmid.no_done", {31'd0, saw}, 32'd0);
    run_op("ADD0+0", 0, 0, 0, 1'b0);
    check_val("ADD0.plan", {23'd0, result, fz}, {23'd0, 8'd0, 1'b1});

    // N=4 regression
    run4("N4_XOR", 4'd4, 4'hA, 4'hF, 8'h05, 5'b00000, 1);
    run4("N4_ILLEGAL12", 4'd12, 4'h7, 4'h3, 8'h00, 5'b01000, 1);
    run4("N4_MUL15x15", 4'd7, 4'hF, 4'hF, 8'hE1, 5'b00100, 5);
    run4("N4_DIV13/3", 4'd8, 4'hD, 4'h3, 8'h04, 5'b00000, 5);
    run4("N4_SUB3-4", 4'd1, 4'h3, 4'h4, 8'h0F, 5'b10100, 1);

    repeat (2) @(posedge clk);
    check_val("sb.drain", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
